// File: rtl/ccff_chain_loader.sv
// Configuration-chain writer: serializes handshaked bitstream words onto ccff_head, MSB first.
// Optional CRC-8 readback check over a recirculated chain: define CCFF_CHAIN_LOADER_READBACK_EN.
module ccff_chain_loader #(
  parameter int unsigned CHAIN_LEN = 2,
  parameter int unsigned WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int unsigned IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
    , ST_READBACK
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              head_q, head_d;
  logic              shift_en_q, shift_en_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

`ifdef CCFF_CHAIN_LOADER_READBACK_EN
  logic [7:0] crc_w_q, crc_w_d;
  logic [7:0] crc_r_q, crc_r_d;
  logic       err_q, err_d;

  // Serial CRC-8, poly 0x07, MSB first
  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
    crc_step = {c[6:0], 1'b0} ^ (((c[7] ^ b) == 1'b1) ? 8'h07 : 8'h00);
  endfunction
`endif

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    idx_d   = idx_q;
    word_d  = word_q;
    head_d  = 1'b0;
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
    crc_w_d = crc_w_q;
    crc_r_d = crc_r_q;
    err_d   = err_q;
`endif

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_LOAD;
          rem_d   = CNT_W'(CHAIN_LEN);
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
          crc_w_d = 8'h00;
          crc_r_d = 8'h00;
          err_d   = 1'b0;
`endif
        end
      end
      ST_LOAD: begin
        if (cfg_valid) begin
          word_d  = cfg_data;
          idx_d   = IDX_W'(WORD_W - 1);
          head_d  = cfg_data[WORD_W-1];
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        rem_d = rem_q - 1'b1;
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
        crc_w_d = crc_step(crc_w_q, head_q);
`endif
        // Chain length, not word boundary, ends the load; leftover word bits are dropped
        if (rem_q == CNT_W'(1)) begin
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
          state_d = ST_READBACK;
          rem_d   = CNT_W'(CHAIN_LEN);
`else
          state_d = ST_DONE;
`endif
        end else if (idx_q == '0) begin
          state_d = ST_LOAD;
        end else begin
          idx_d  = idx_q - 1'b1;
          head_d = word_q[idx_d];
        end
      end
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
      ST_READBACK: begin
        rem_d   = rem_q - 1'b1;
        crc_r_d = crc_step(crc_r_q, ccff_tail);
        if (rem_q == CNT_W'(1)) begin
          state_d = ST_DONE;
          err_d   = (crc_r_d != crc_w_q);
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered decodes of the next state
    ready_d    = (state_d == ST_LOAD);
    done_d     = (state_d == ST_DONE);
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
    shift_en_d = (state_d == ST_SHIFT) || (state_d == ST_READBACK);
    busy_d     = (state_d == ST_LOAD) || (state_d == ST_SHIFT) || (state_d == ST_READBACK);
`else
    shift_en_d = (state_d == ST_SHIFT);
    busy_d     = (state_d == ST_LOAD) || (state_d == ST_SHIFT);
`endif
  end

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state_q    <= ST_IDLE;
      rem_q      <= '0;
      idx_q      <= '0;
      word_q     <= '0;
      head_q     <= 1'b0;
      shift_en_q <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      idx_q      <= idx_d;
      word_q     <= word_d;
      head_q     <= head_d;
      shift_en_q <= shift_en_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

`ifdef CCFF_CHAIN_LOADER_READBACK_EN
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      crc_w_q <= 8'h00;
      crc_r_q <= 8'h00;
      err_q   <= 1'b0;
    end else begin
      crc_w_q <= crc_w_d;
      crc_r_q <= crc_r_d;
      err_q   <= err_d;
    end
  end

  // Recirculation must be zero-latency so the loop length stays CHAIN_LEN
  assign ccff_head = (state_q == ST_READBACK) ? ccff_tail : head_q;
  assign err       = err_q;
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
  assign ccff_head   = head_q;
  assign err         = 1'b0;
`endif

  assign cfg_ready     = ready_q;
  assign ccff_shift_en = shift_en_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader: a 2-bit and a 20-bit instance, each driving a shift-register chain model.
module tb_ccff_chain_loader;

`ifdef CCFF_CHAIN_LOADER_READBACK_EN
  localparam int EXP_EN20 = 40;
  localparam int RB2      = 2;
`else
  localparam int EXP_EN20 = 20;
  localparam int RB2      = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   checks;
  int   errors;

  logic       start2, valid2, ready2, head2, en2, tail2, busy2, done2, err2;
  logic [7:0] data2;
  logic [1:0] chain2;

  logic        start20, valid20, ready20, head20, en20, tail20, busy20, done20, err20;
  logic [7:0]  data20;
  logic [19:0] chain20;
  logic        inj;

  logic mon_clr;
  int   cnt20, hs20, hs2, drise20;
  logic done20_d;

  assign tail2  = chain2[1];
  assign tail20 = chain20[19] ^ inj;

  ccff_chain_loader #(.CHAIN_LEN(2), .WORD_W(8)) u_dut2 (
    .prog_clk(clk), .prog_reset(rst), .start(start2), .cfg_data(data2),
    .cfg_valid(valid2), .cfg_ready(ready2), .ccff_head(head2), .ccff_shift_en(en2),
    .ccff_tail(tail2), .busy(busy2), .done(done2), .err(err2)
  );

  ccff_chain_loader #(.CHAIN_LEN(20), .WORD_W(8)) u_dut20 (
    .prog_clk(clk), .prog_reset(rst), .start(start20), .cfg_data(data20),
    .cfg_valid(valid20), .cfg_ready(ready20), .ccff_head(head20), .ccff_shift_en(en20),
    .ccff_tail(tail20), .busy(busy20), .done(done20), .err(err20)
  );

  // Chain models and event counters
  always @(posedge clk) begin
    if (en2) chain2 <= {chain2[0], head2};
    if (mon_clr) begin
      chain20  <= '0;
      cnt20    <= 0;
      hs20     <= 0;
      hs2      <= 0;
      drise20  <= 0;
      done20_d <= done20;
    end else begin
      if (en20) begin
        chain20 <= {chain20[18:0], head20};
        cnt20   <= cnt20 + 1;
      end
      if (ready20 && valid20) hs20 <= hs20 + 1;
      if (ready2 && valid2) hs2 <= hs2 + 1;
      done20_d <= done20;
      if (done20 && !done20_d) drise20 <= drise20 + 1;
    end
  end

  task automatic clear_mon();
    @(negedge clk); mon_clr = 1'b1;
    @(negedge clk); mon_clr = 1'b0;
  endtask

  task automatic load20(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                        input int stall, input bit poke, input bit flip);
    int g;
    int c0;
    bit inj_done;
    clear_mon();
    @(negedge clk); start20 = 1'b1;
    @(negedge clk); start20 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1 && stall > 0) begin
        valid20 = 1'b0;
        g = 0;
        while (!ready20 && g < 100) begin @(negedge clk); g++; end
        c0 = cnt20;
        repeat (stall) @(negedge clk);
        checks++;
        if (en20 !== 1'b0 || cnt20 !== c0 || ready20 !== 1'b1) begin
          errors++;
          $display("FAIL backpressure: en=%b shifts=%0d ready=%b, expected en=0 shifts=%0d ready=1",
                   en20, cnt20, ready20, c0);
        end
      end
      data20  = (i == 0) ? w0 : (i == 1) ? w1 : w2;
      valid20 = 1'b1;
      g = 0;
      while (!ready20 && g < 100) begin @(negedge clk); g++; end
      checks++;
      if (g >= 100) begin
        errors++;
        $display("FAIL ready_timeout: word %0d never accepted, expected cfg_ready within 100 cycles", i);
      end
      @(negedge clk);
      valid20 = 1'b0;
      if (i == 0 && poke) begin
        start20 = 1'b1;
        @(negedge clk);
        start20 = 1'b0;
      end
    end
    g = 0;
    inj_done = 1'b0;
    while (!done20 && g < 200) begin
      if (flip && !inj_done && cnt20 == 20 && en20) begin
        inj = 1'b1;
        inj_done = 1'b1;
      end else begin
        inj = 1'b0;
      end
      @(negedge clk);
      g++;
    end
    inj = 1'b0;
    checks++;
    if (g >= 200) begin
      errors++;
      $display("FAIL done_timeout: done=%b after 200 cycles, expected 1", done20);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({ready2, head2, en2, busy2, done2, err2} !== 6'b0) begin
      errors++;
      $display("FAIL reset_dut2: outputs=%b expected 000000", {ready2, head2, en2, busy2, done2, err2});
    end
    checks++;
    if (ready20 !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready20); end
    checks++;
    if (en20 !== 1'b0 || head20 !== 1'b0) begin
      errors++; $display("FAIL reset_shift: en=%b head=%b expected 0 0", en20, head20);
    end
    checks++;
    if (busy20 !== 1'b0 || done20 !== 1'b0 || err20 !== 1'b0) begin
      errors++; $display("FAIL reset_status: busy=%b done=%b err=%b expected 0 0 0", busy20, done20, err20);
    end
    rst = 1'b0;
    mon_clr = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy20 !== 1'b0 || ready20 !== 1'b0 || busy2 !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: busy20=%b ready20=%b busy2=%b expected 0 0 0", busy20, ready20, busy2);
    end
  endtask

  task automatic test_single_word();
    clear_mon();
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    checks++;
    if (ready2 !== 1'b1 || busy2 !== 1'b1 || en2 !== 1'b0) begin
      errors++; $display("FAIL load_state: ready=%b busy=%b en=%b expected 1 1 0", ready2, busy2, en2);
    end
    data2 = 8'h80; valid2 = 1'b1;
    @(negedge clk); valid2 = 1'b0;
    checks++;
    if (en2 !== 1'b1 || head2 !== 1'b1 || ready2 !== 1'b0) begin
      errors++; $display("FAIL shift_bit0: en=%b head=%b ready=%b expected 1 1 0", en2, head2, ready2);
    end
    @(negedge clk);
    checks++;
    if (en2 !== 1'b1 || head2 !== 1'b0) begin
      errors++; $display("FAIL shift_bit1: en=%b head=%b expected 1 0", en2, head2);
    end
    repeat (RB2) @(negedge clk);
    @(negedge clk);
    checks++;
    if (done2 !== 1'b1 || busy2 !== 1'b0 || en2 !== 1'b0 || head2 !== 1'b0) begin
      errors++; $display("FAIL done2: done=%b busy=%b en=%b head=%b expected 1 0 0 0", done2, busy2, en2, head2);
    end
    checks++;
    if (hs2 !== 1 || chain2 !== 2'b10 || err2 !== 1'b0) begin
      errors++; $display("FAIL result2: handshakes=%0d chain=%b err=%b expected 1 10 0", hs2, chain2, err2);
    end
  endtask

  task automatic check_load20(input string name, input logic [19:0] exp_chain, input logic exp_err);
    checks++;
    if (chain20 !== exp_chain) begin
      errors++; $display("FAIL %s_chain: got %05h expected %05h", name, chain20, exp_chain);
    end
    checks++;
    if (hs20 !== 3 || cnt20 !== EXP_EN20) begin
      errors++; $display("FAIL %s_counts: handshakes=%0d shifts=%0d expected 3 %0d", name, hs20, cnt20, EXP_EN20);
    end
    checks++;
    if (done20 !== 1'b1 || busy20 !== 1'b0 || en20 !== 1'b0 || head20 !== 1'b0 || err20 !== exp_err) begin
      errors++;
      $display("FAIL %s_status: done=%b busy=%b en=%b head=%b err=%b expected 1 0 0 0 %b",
               name, done20, busy20, en20, head20, err20, exp_err);
    end
  endtask

  task automatic test_multi_word();
    load20(8'hA5, 8'h3C, 8'hF0, 0, 1'b0, 1'b0);
    check_load20("multi", 20'hA53CF, 1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if (done20 !== 1'b1 || drise20 !== 1) begin
      errors++; $display("FAIL done_hold: done=%b rises=%0d expected 1 1", done20, drise20);
    end
  endtask

  task automatic test_backpressure();
    load20(8'h3C, 8'hA5, 8'h81, 5, 1'b0, 1'b0);
    check_load20("bp", 20'h3CA58, 1'b0);
  endtask

  task automatic test_reset_mid_load();
    int g;
    clear_mon();
    @(negedge clk); start20 = 1'b1;
    @(negedge clk); start20 = 1'b0;
    data20 = 8'hFF; valid20 = 1'b1;
    g = 0;
    while (!ready20 && g < 100) begin @(negedge clk); g++; end
    @(negedge clk); valid20 = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (en20 !== 1'b1 || cnt20 !== 2) begin
      errors++; $display("FAIL mid_shift: en=%b shifts=%0d expected 1 2", en20, cnt20);
    end
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    checks++;
    if ({ready20, head20, en20, busy20, done20, err20} !== 6'b0) begin
      errors++; $display("FAIL abort: outputs=%b expected 000000", {ready20, head20, en20, busy20, done20, err20});
    end
    @(negedge clk);
    checks++;
    if (busy20 !== 1'b0 || ready20 !== 1'b0) begin
      errors++; $display("FAIL abort_idle: busy=%b ready=%b expected 0 0", busy20, ready20);
    end
    load20(8'h5A, 8'hC3, 8'h9F, 0, 1'b0, 1'b0);
    check_load20("reload", 20'h5AC39, 1'b0);
  endtask

  task automatic test_start_during_shift();
    load20(8'h0F, 8'hF0, 8'h55, 0, 1'b1, 1'b0);
    check_load20("poke", 20'h0FF05, 1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if (drise20 !== 1 || done20 !== 1'b1) begin
      errors++; $display("FAIL single_done: rises=%0d done=%b expected 1 1", drise20, done20);
    end
  endtask

`ifdef CCFF_CHAIN_LOADER_READBACK_EN
  task automatic test_readback_error();
    load20(8'hA5, 8'h3C, 8'hF0, 0, 1'b0, 1'b1);
    check_load20("flip", 20'h253CF, 1'b1);
    load20(8'hA5, 8'h3C, 8'hF0, 0, 1'b0, 1'b0);
    check_load20("clean", 20'hA53CF, 1'b0);
  endtask
`endif

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; mon_clr = 1'b1; inj = 1'b0;
    start2 = 1'b0; valid2 = 1'b0; data2 = 8'h00; chain2 = 2'b00;
    start20 = 1'b0; valid20 = 1'b0; data20 = 8'h00;
    test_reset();
    test_single_word();
    test_multi_word();
    test_backpressure();
    test_reset_mid_load();
    test_start_during_shift();
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
    test_readback_error();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
